// File: rtl/adc_capture_buf.sv
`timescale 1ns/1ps
// adc_capture_buf: circular ADC sample buffer with a pre-trigger window and
// request/valid readout for the SPI transmit path.
// Optional macro ADC_CAPTURE_FORCE_EN adds input force_trig, which ends
// WAIT_TRIG like a trigger edge (auto/free-run mode).
module adc_capture_buf #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              trigger,
  input  logic              arm,
  input  logic [ADDR_W-1:0] pre_len,
`ifdef ADC_CAPTURE_FORCE_EN
  input  logic              force_trig,
`endif
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READOUT} state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] rd_count;
  logic              trig_d;
  logic              trig_edge;
  logic              trig_hit;
  logic              wr_en;
  logic              start;
  logic              capture;
  logic              rd_fire;

  assign trig_edge = trigger & ~trig_d;
`ifdef ADC_CAPTURE_FORCE_EN
  assign trig_hit = trig_edge | force_trig;
`else
  assign trig_hit = trig_edge;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state, write enable, datapath strobes and status outputs.
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    start   = 1'b0;
    capture = 1'b0;
    rd_fire = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          start   = 1'b1;
          state_n = PRE;
        end
      end
      PRE: begin
        busy = 1'b1;
        if (pre_q == '0) begin
          state_n = WAIT_TRIG;
        end else begin
          wr_en = 1'b1;
          if ((cnt + ADDR_W'(1)) == pre_q) state_n = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (trig_hit) begin
          capture = 1'b1;
          state_n = (pre_q == '1) ? READOUT : POST;
        end
      end
      POST: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (post_cnt == ADDR_W'(1)) state_n = READOUT;
      end
      READOUT: begin
        done = 1'b1;
        if (arm) begin
          start   = 1'b1;
          state_n = PRE;
        end else if (rd_en) begin
          rd_fire = 1'b1;
          if (&rd_count) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pointers, counters, trigger delay and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      post_cnt <= '0;
      rd_count <= '0;
      trig_d   <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      trig_d   <= trigger;
      rd_valid <= rd_fire;
      rd_last  <= rd_fire & (&rd_count);
      if (start) begin
        pre_q    <= pre_len;
        wr_ptr   <= '0;
        cnt      <= '0;
        rd_count <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (state == PRE)  cnt      <= cnt + ADDR_W'(1);
        if (state == POST) post_cnt <= post_cnt - ADDR_W'(1);
      end
      if (capture) begin
        rd_ptr   <= wr_ptr - pre_q;
        post_cnt <= ~pre_q;
      end
      if (rd_fire) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        rd_count <= rd_count + ADDR_W'(1);
      end
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

endmodule

// File: tb/tb_adc_capture_buf.sv
`timescale 1ns/1ps
// tb_adc_capture_buf: directed bench for adc_capture_buf with DEPTH=16 and a
// free-running ramp on data.
module tb_adc_capture_buf;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic              trigger;
  logic              arm;
  logic [ADDR_W-1:0] pre_len;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;
  logic              done;
`ifdef ADC_CAPTURE_FORCE_EN
  logic              force_trig;
`endif

  int checks = 0;
  int errors = 0;

  adc_capture_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .trigger  (trigger),
    .arm      (arm),
    .pre_len  (pre_len),
`ifdef ADC_CAPTURE_FORCE_EN
    .force_trig(force_trig),
`endif
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .busy     (busy),
    .done     (done)
  );

  // 10 ns sample clock.
  always #5 clk = ~clk;

  // Advance one sample: wait for the edge, then present the next ramp value.
  task applyStimulus();
    @(posedge clk);
    #1;
    data = data + 8'd1;
  endtask

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run the ramp until the value v is being presented.
  task runTo(input logic [7:0] v);
    int n;
    n = 0;
    while (data != v && n < 300) begin
      applyStimulus();
      n++;
    end
    if (n >= 300) begin
      errors++;
      $display("[TB] FAIL run_to timeout waiting for data=%0d", v);
    end
  endtask

  // Issue n reads expecting first, first+1, ...; optional idle cycle between.
  task readBurst(input string tag, input int first, input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      rd_en = 1'b1;
      applyStimulus();
      rd_en = 1'b0;
      checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
      checkOutput({tag, "_data"},  32'(rd_data),  32'((first + k) % 256));
      checkOutput({tag, "_last"},  32'(rd_last),  32'(k == DEPTH - 1));
      if (gap) begin
        applyStimulus();
        checkOutput({tag, "_gap_valid"}, 32'(rd_valid), 32'd0);
      end
    end
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    data    = 8'd0;
    trigger = 1'b0;
    arm     = 1'b0;
    pre_len = '0;
    rd_en   = 1'b0;
    rst_n   = 1'b0;
`ifdef ADC_CAPTURE_FORCE_EN
    force_trig = 1'b0;
`endif
    repeat (3) applyStimulus();
    rst_n = 1'b1;

    // 1. Reset mid-stream, then reads while idle give nothing.
    repeat (5) applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rd_data",  32'(rd_data),  32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_last",  32'(rd_last),  32'd0);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_done",     32'(done),     32'd0);
    applyStimulus();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
      applyStimulus();
      rd_en = 1'b0;
      checkOutput("idle_rd_valid", 32'(rd_valid), 32'd0);
    end

    // 2. Normal capture: pre_len=4, arm at data 0, trigger rises at 20.
    runTo(8'd0);
    arm = 1'b1; pre_len = 4'd4;
    applyStimulus();
    arm = 1'b0;
    checkOutput("n_pre_busy", 32'(busy), 32'd1);
    checkOutput("n_pre_done", 32'(done), 32'd0);
    runTo(8'd20);
    checkOutput("n_wait_busy", 32'(busy), 32'd1);
    trigger = 1'b1;
    applyStimulus();
    trigger = 1'b0;
    checkOutput("n_post_busy", 32'(busy), 32'd1);
    runTo(8'd31);
    checkOutput("n_post_last_done", 32'(done), 32'd0);
    applyStimulus();
    checkOutput("n_ro_done",  32'(done),     32'd1);
    checkOutput("n_ro_busy",  32'(busy),     32'd0);
    checkOutput("n_ro_valid", 32'(rd_valid), 32'd0);
    readBurst("n_rd", 16, DEPTH, 1'b0);
    checkOutput("n_end_done", 32'(done), 32'd0);
    checkOutput("n_end_busy", 32'(busy), 32'd0);
    applyStimulus();
    checkOutput("n_end_valid", 32'(rd_valid), 32'd0);
    checkOutput("n_end_last",  32'(rd_last),  32'd0);

    // 3. Zero pre-trigger: trigger rises at 50, window 50..65.
    runTo(8'd45);
    arm = 1'b1; pre_len = 4'd0;
    applyStimulus();
    arm = 1'b0;
    runTo(8'd50);
    trigger = 1'b1;
    applyStimulus();
    trigger = 1'b0;
    runTo(8'd65);
    checkOutput("z_post_done", 32'(done), 32'd0);
    applyStimulus();
    checkOutput("z_ro_done", 32'(done), 32'd1);
    readBurst("z_rd", 50, DEPTH, 1'b1);
    checkOutput("z_end_done", 32'(done), 32'd0);

    // 4. Level already high at arm does not trigger; later rise at 70 does.
    runTo(8'd30);
    trigger = 1'b1;
    runTo(8'd35);
    arm = 1'b1; pre_len = 4'd4;
    applyStimulus();
    arm = 1'b0;
    runTo(8'd60);
    checkOutput("h_held_busy", 32'(busy), 32'd1);
    checkOutput("h_held_done", 32'(done), 32'd0);
    trigger = 1'b0;
    runTo(8'd70);
    trigger = 1'b1;
    applyStimulus();
    trigger = 1'b0;
    runTo(8'd82);
    checkOutput("h_ro_done", 32'(done), 32'd1);
    readBurst("h_rd", 66, DEPTH, 1'b0);

    // 5. Re-arm during readout, then reset during POST, then a clean capture.
    runTo(8'd100);
    arm = 1'b1; pre_len = 4'd4;
    applyStimulus();
    arm = 1'b0;
    runTo(8'd110);
    trigger = 1'b1;
    applyStimulus();
    trigger = 1'b0;
    runTo(8'd122);
    checkOutput("a_ro_done", 32'(done), 32'd1);
    readBurst("a_rd", 106, 3, 1'b0);
    arm = 1'b1; rd_en = 1'b1; pre_len = 4'd4;
    applyStimulus();
    arm = 1'b0; rd_en = 1'b0;
    checkOutput("a_rearm_valid", 32'(rd_valid), 32'd0);
    checkOutput("a_rearm_done",  32'(done),     32'd0);
    checkOutput("a_rearm_busy",  32'(busy),     32'd1);
    runTo(8'd140);
    trigger = 1'b1;
    applyStimulus();
    trigger = 1'b0;
    applyStimulus();
    checkOutput("a_post_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("a_rst_busy",    32'(busy),    32'd0);
    checkOutput("a_rst_done",    32'(done),    32'd0);
    checkOutput("a_rst_rd_data", 32'(rd_data), 32'd0);
    applyStimulus();
    rst_n = 1'b1;
    runTo(8'd190);
    arm = 1'b1; pre_len = 4'd2;
    applyStimulus();
    arm = 1'b0;
    runTo(8'd200);
    trigger = 1'b1;
    applyStimulus();
    trigger = 1'b0;
    runTo(8'd214);
    checkOutput("a_ro_done2", 32'(done), 32'd1);
    readBurst("a_rd2", 198, DEPTH, 1'b0);

    // 6. Forced trigger with the level held low.
    runTo(8'd30);
    arm = 1'b1; pre_len = 4'd2;
    applyStimulus();
    arm = 1'b0;
    runTo(8'd40);
`ifdef ADC_CAPTURE_FORCE_EN
    force_trig = 1'b1;
    applyStimulus();
    force_trig = 1'b0;
    runTo(8'd54);
    checkOutput("f_ro_done", 32'(done), 32'd1);
    readBurst("f_rd", 38, DEPTH, 1'b0);
`else
    applyStimulus();
    runTo(8'd70);
    checkOutput("f_noforce_done", 32'(done), 32'd0);
    checkOutput("f_noforce_busy", 32'(busy), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_buf.md
Name: adc_capture_buf

Overview:
- Capture stage directly downstream of the ADC trigger comparator.
- Continuously writes 8-bit ADC samples into a circular on-chip buffer once armed.
- On a rising edge of the comparator's trigger level, freezes a window holding pre_len samples before the trigger sample, the trigger sample itself, and the remaining samples after it.
- Readout is sample by sample through a request/valid handshake, for the SPI transmit path.

Parameters:
DATA_W, 8, ADC sample width
ADDR_W, 10, buffer address width; DEPTH = 2^ADDR_W samples per capture

Ports:
clk  in  1  sample clock; one ADC sample per cycle
rst_n  in  1  asynchronous active-low reset
data  in  DATA_W  ADC sample
trigger  in  1  hysteresis trigger level from comparator
arm  in  1  single-cycle pulse: start new capture
pre_len  in  ADDR_W  pre-trigger sample count, sampled on accepted arm
rd_en  in  1  read request, one sample per asserted cycle
rd_data  out  DATA_W  read sample
rd_valid  out  1  rd_data valid, one cycle after accepted rd_en
rd_last  out  1  asserted with rd_valid of final (DEPTH-th) sample
busy  out  1  capture in progress
done  out  1  capture complete, unread data available

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; rd_data=0, rd_valid=0, rd_last=0, busy=0, done=0; all pointers and counters 0; trig_d=0. Buffer RAM contents are not cleared.
- Edge detect: trig_d <= trigger every cycle in every state; edge = trigger & ~trig_d. A level already high at arm does not trigger; it must fall and rise again.
- States:
  - IDLE: arm -> PRE. Latch pre_len; wr_ptr=0; cnt=0.
  - PRE:
    - Write data at wr_ptr each cycle; wr_ptr++ (wraps mod DEPTH); cnt++.
    - When cnt reaches latched pre_len -> WAIT_TRIG. If pre_len=0, the transition is immediate on the first PRE cycle and no write occurs.
    - Edges during PRE are ignored.
  - WAIT_TRIG:
    - Keep writing circularly.
    - On edge: the sample written that cycle is the trigger sample.
    - rd_ptr = (wr_ptr - pre_len) mod DEPTH; post_cnt = DEPTH-1-pre_len; then -> POST. If post_cnt=0, go directly to READOUT.
  - POST: write, wr_ptr++, post_cnt--. The cycle writing the last sample (post_cnt 1->0) -> READOUT.
  - READOUT:
    - done=1.
    - Each rd_en cycle: RAM read at rd_ptr, rd_ptr++.
    - rd_data/rd_valid appear next cycle (1-cycle latency; registered sync-RAM output).
    - On the DEPTH-th accepted rd_en -> IDLE, done falls the same edge. The final rd_valid and rd_last still assert the following cycle.
- busy=1 in PRE, WAIT_TRIG, POST.
- Output index k of the readout equals the sample written k-pre_len cycles relative to the trigger sample. Index pre_len is the trigger sample. The trigger input lags its source sample by one clock; this offset is fixed and not compensated.
- Address arithmetic is modulo DEPTH (natural ADDR_W wrap). pre_len max is DEPTH-1, giving post_cnt 0.
- arm is accepted only in IDLE or READOUT. In READOUT it discards unread data and restarts PRE; arm has priority over a simultaneous rd_en, which is dropped. arm is ignored in PRE, WAIT_TRIG, and POST.
- rd_en outside READOUT is ignored; rd_valid stays 0.
- rst_n low in any state returns to IDLE at once. A pending rd_valid is cancelled.

Optional Feature:
Macro ADC_CAPTURE_FORCE_EN.
- Defined: adds input force_trig (1 bit). force_trig high in WAIT_TRIG acts exactly as a trigger edge (auto/free-run mode); OR-ed with edge. Ignored in all other states.
- Undefined: port absent; only trigger edges end WAIT_TRIG.

Test Plan:
Bench setup: ADDR_W=4 (DEPTH=16); data is a free-running ramp 0,1,2,... (mod 256).
1. Reset check: assert rst_n low mid-stream -> rd_data=0, rd_valid=0, rd_last=0, busy=0, done=0 immediately; rd_en pulses afterwards produce no rd_valid.
2. Normal capture: pre_len=4, arm on cycle where data=0, trigger rises with data=20 -> busy until done; 16 rd_en pulses return 16..31; rd_valid 1 cycle after each rd_en; rd_last only with 31; state IDLE after.
3. Zero pre-trigger: pre_len=0, trigger rises at data=50 -> readout 50..65.
4. Level held high: trigger high before arm and held for 30 cycles -> stays in WAIT_TRIG, done=0; trigger falls, rises at data=70 with pre_len=4 -> readout 66..81.
5. Re-arm/abort: in READOUT after 3 reads, pulse arm together with rd_en -> no rd_valid for that rd_en, done=0, busy=1 next cycle; reset during POST -> busy=0, done=0, later arm captures normally.
6. With ADC_CAPTURE_FORCE_EN: pre_len=2, trigger held 0, force_trig pulse at data=40 -> readout 38..53; without macro, same stimulus minus port leaves done=0.
